// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared FSM states and constants for the load/store unit
package mem_access_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;
  localparam int WAIT_W = 8;
endpackage

// File: rtl/byte_lane_sel.sv
// byte_lane_sel: store byte-enable/lane replication and load lane extraction
module byte_lane_sel
  import mem_access_pkg::*;
(
  input  logic [1:0]  st_lane,
  input  logic        st_byte,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_lane,
  input  logic        ld_byte,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  always_comb begin
    st_be   = st_byte ? 4'b0001 << st_lane : BE_WORD;
    st_data = st_byte ? {4{st_wdata[7:0]}} : st_wdata;
    ld_data = ld_byte ? {24'h0, ld_rdata[{ld_lane, 3'b000} +: 8]} : ld_rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store RAM access FSM; byte lanes enabled by MEM_ACCESS_BYTE_EN
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_byte,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_rd,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  output logic              wb_valid,
  output logic [3:0]        wb_addr,
  output logic [31:0]       wb_data,
  output logic              stall,
  output logic              err
);
  state_t state;
  logic [WAIT_W-1:0] cnt;
  logic load_q;
  logic [3:0] rd_q;
  logic [3:0] st_be;
  logic [31:0] st_data, ld_data;
  logic unused_bits;
`ifdef MEM_ACCESS_BYTE_EN
  logic [1:0] lane_q;
  logic byte_q;
  byte_lane_sel u_lane (
    .st_lane (req_addr[1:0]),
    .st_byte (req_byte),
    .st_wdata(req_wdata),
    .st_be   (st_be),
    .st_data (st_data),
    .ld_lane (lane_q),
    .ld_byte (byte_q),
    .ld_rdata(ram_rdata),
    .ld_data (ld_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lane_q <= '0;
      byte_q <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      lane_q <= req_addr[1:0];
      byte_q <= req_byte;
    end
  assign unused_bits = ^req_addr[31:ADDR_W+2];
`else
  assign st_be = BE_WORD;
  assign st_data = req_wdata;
  assign ld_data = ram_rdata;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0], req_byte};
`endif
  // Handshake strobes decode the async-reset state so reset drops them at once.
  assign req_ready = state == IDLE;
  assign stall = state != IDLE;
  assign ram_en = state == BUSY;
  assign ram_wr = ram_en & ~load_q;
  assign wb_valid = state == RESP;
  assign wb_addr = rd_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      load_q <= 1'b0;
      rd_q <= '0;
      ram_addr <= '0;
      ram_wdata <= '0;
      ram_be <= BE_NONE;
      wb_data <= '0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          state <= BUSY;
          cnt <= '0;
          load_q <= req_load;
          rd_q <= req_rd;
          ram_addr <= req_addr[ADDR_W+1:2];
          ram_wdata <= st_data;
          ram_be <= req_load ? BE_NONE : st_be;
        end
        BUSY: if (ram_ack) begin
          state <= load_q ? RESP : IDLE;
          if (load_q) wb_data <= ld_data;
        end else if (cnt == WAIT_W'(MAX_WAIT - 1)) begin
          state <= IDLE;
          err <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector bench for mem_access_unit
module tb_mem_access_unit;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_load = 0, req_byte = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, ram_rdata = 0;
  logic [3:0] req_rd = 0;
  logic ram_ack = 0;
  logic req_ready, ram_en, ram_wr, wb_valid, stall, err;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata, wb_data;
  logic [3:0] ram_be, wb_addr;
  int n_chk = 0, n_fail = 0;
`ifdef MEM_ACCESS_BYTE_EN
  localparam bit BEN = 1;
`else
  localparam bit BEN = 0;
`endif
  mem_access_unit #(.ADDR_W(11), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_byte(req_byte), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .ram_en(ram_en), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ld, by;
    logic [31:0] addr, wdata;
    logic [3:0] rd;
    logic [31:0] rdata;
    int dly;
    logic [10:0] e_addr;
    logic [3:0] e_be;
    logic [31:0] e_wdata, e_wb;
  } vec_t;
  vec_t v[9];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic run(input vec_t t);
    int st = 0;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1; req_load = t.ld; req_byte = t.by;
    req_addr = t.addr; req_wdata = t.wdata; req_rd = t.rd;
    @(negedge clk);
    req_valid = 0; req_addr = ~t.addr; req_wdata = ~t.wdata;
    for (int i = 0; i <= t.dly; i++) begin
      st += int'(stall);
      chk("ram_en", ram_en, 1);
      chk("ram_wr", ram_wr, !t.ld);
      chk("ram_addr", ram_addr, t.e_addr);
      chk("ram_be", ram_be, t.e_be);
      if (!t.ld) chk("ram_wdata", ram_wdata, t.e_wdata);
      if (i == t.dly) begin ram_ack = 1; ram_rdata = t.rdata; end
      @(negedge clk);
    end
    ram_ack = 0; ram_rdata = 32'h0BAD_0BAD;
    chk("no_err", err, 0);
    if (t.ld) begin
      st += int'(stall);
      chk("wb_valid", wb_valid, 1);
      chk("wb_addr", wb_addr, t.rd);
      chk("wb_data", wb_data, t.e_wb);
      chk("ready_resp", req_ready, 0);
      @(negedge clk);
    end
    chk("wb_valid_end", wb_valid, 0);
    chk("ready_back", req_ready, 1);
    chk("stall_cycles", st, t.dly + 1 + int'(t.ld));
  endtask
  initial begin
    v[0] = '{1, 0, 32'h10, 0, 5, 32'hDEAD_BEEF, 1, 11'h4, 4'h0, 0, 32'hDEAD_BEEF};
    v[1] = '{0, 0, 32'h20, 32'h1234_5678, 0, 0, 0, 11'h8, 4'hF, 32'h1234_5678, 0};
    v[2] = '{1, 0, 32'h103, 0, 15, 32'hCAFE_F00D, 0, 11'h40, 4'h0, 0, 32'hCAFE_F00D};
    v[3] = '{0, 0, 32'hFFFF_FFFE, 32'hA5A5_0F0F, 0, 0, 3, 11'h7FF, 4'hF, 32'hA5A5_0F0F, 0};
    v[4] = '{1, 0, 32'h44, 0, 1, 32'h0F0F_1234, 3, 11'h11, 4'h0, 0, 32'h0F0F_1234};
    v[5] = '{0, 1, 32'h23, 32'hAB, 0, 0, 0, 11'h8, BEN ? 4'h8 : 4'hF,
             BEN ? 32'hABAB_ABAB : 32'hAB, 0};
    v[6] = '{1, 1, 32'h22, 0, 2, 32'h11CC_3344, 0, 11'h8, 4'h0, 0,
             BEN ? 32'hCC : 32'h11CC_3344};
    v[7] = '{1, 1, 32'h21, 0, 3, 32'h11CC_3344, 2, 11'h8, 4'h0, 0,
             BEN ? 32'h33 : 32'h11CC_3344};
    v[8] = '{0, 1, 32'h0, 32'h1234_567E, 0, 0, 1, 11'h0, BEN ? 4'h1 : 4'hF,
             BEN ? 32'h7E7E_7E7E : 32'h1234_567E, 0};
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", err, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_be", ram_be, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    @(negedge clk); rst = 0;
    foreach (v[i]) run(v[i]);
    @(negedge clk);
    req_valid = 1; req_load = 1; req_byte = 0; req_addr = 32'h40; req_rd = 9;
    @(negedge clk); req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_ram_en", ram_en, 1);
      chk("to_err_early", err, 0);
      @(negedge clk);
    end
    chk("to_err_pulse", err, 1);
    chk("to_ready", req_ready, 1);
    chk("to_ram_en_off", ram_en, 0);
    chk("to_wb_valid", wb_valid, 0);
    @(negedge clk);
    chk("to_err_clear", err, 0);
    chk("to_wb_valid2", wb_valid, 0);
    run(v[1]);
    @(negedge clk);
    req_valid = 1; req_load = 1; req_addr = 32'h60; req_rd = 4;
    @(negedge clk); req_valid = 0;
    chk("rm_busy1", ram_en, 1);
    @(negedge clk);
    chk("rm_busy2", ram_en, 1);
    rst = 1; #1;
    chk("rm_ram_en", ram_en, 0);
    chk("rm_stall", stall, 0);
    chk("rm_wb_valid", wb_valid, 0);
    chk("rm_ready", req_ready, 1);
    @(negedge clk); rst = 0;
    @(negedge clk); ram_ack = 1; ram_rdata = 32'h5555_AAAA;
    @(negedge clk); ram_ack = 0;
    chk("stray_wb_valid", wb_valid, 0);
    chk("stray_ready", req_ready, 1);
    chk("stray_ram_en", ram_en, 0);
    @(negedge clk);
    req_valid = 1; req_load = 1; req_byte = 0; req_addr = 32'h50; req_rd = 6;
    @(negedge clk);
    chk("b2b_busy_ready", req_ready, 0);
    chk("b2b_addr1", ram_addr, 11'h14);
    req_addr = 32'h54; req_rd = 7;
    ram_ack = 1; ram_rdata = 32'h1111_1111;
    @(negedge clk); ram_ack = 0;
    chk("b2b_wb1_valid", wb_valid, 1);
    chk("b2b_wb1_addr", wb_addr, 6);
    chk("b2b_wb1_data", wb_data, 32'h1111_1111);
    chk("b2b_resp_ready", req_ready, 0);
    @(negedge clk);
    chk("b2b_ready2", req_ready, 1);
    chk("b2b_wb_gap", wb_valid, 0);
    @(negedge clk); req_valid = 0;
    chk("b2b_addr2", ram_addr, 11'h15);
    chk("b2b_en2", ram_en, 1);
    ram_ack = 1; ram_rdata = 32'h2222_2222;
    @(negedge clk); ram_ack = 0;
    chk("b2b_wb2_valid", wb_valid, 1);
    chk("b2b_wb2_addr", wb_addr, 7);
    chk("b2b_wb2_data", wb_data, 32'h2222_2222);
    @(negedge clk);
    chk("b2b_idle", req_ready, 1);
    chk("b2b_wb_end", wb_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store stage directly downstream of the register/ALU datapath. It takes the effective address (the datapath's `datapath_out`) and the store data (`str_data`), runs one single-word or single-byte access against data RAM over a request/acknowledge handshake, and returns load results as a register write-back (the datapath's `ram_data2` / `w_addr3` / `w_en3` path). While an access is in flight it stalls the controller.

## Interface
- `ADDR_W`, 11: RAM word-address width; `ram_addr = req_addr[ADDR_W+1:2]`.
- `MAX_WAIT`, 15: cycles spent in BUSY without `ram_ack` before the access is aborted; legal range 1..255.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: access request present.
- `req_ready` out 1: unit can accept a request this cycle.
- `req_load` in 1: 1 = LDR/LDRB, 0 = STR/STRB.
- `req_byte` in 1: byte access (LDRB/STRB).
- `req_addr` in 32: byte address from the datapath.
- `req_wdata` in 32: store data from the register file store port.
- `req_rd` in 4: destination register for loads.
- `ram_en` out 1: RAM access request, held until acknowledged.
- `ram_wr` out 1: 1 = write.
- `ram_addr` out ADDR_W: word address.
- `ram_wdata` out 32: write data.
- `ram_be` out 4: byte-lane write enables.
- `ram_rdata` in 32: read data, valid in the `ram_ack` cycle.
- `ram_ack` in 1: access complete.
- `wb_valid` out 1: one-cycle load write-back strobe.
- `wb_addr` out 4: write-back register.
- `wb_data` out 32: loaded value.
- `stall` out 1: high while the unit is not IDLE.
- `err` out 1: one-cycle pulse when an access times out.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: `req_ready`=1. When `req_valid`=1, latch addr, wdata, rd, load and byte, clear the wait counter, and go to BUSY.
- BUSY: `ram_en`=1. `ram_wr`, `ram_addr`, `ram_wdata` and `ram_be` are driven from the latched request and stay stable.
  - `ram_ack`=1 and load: register the extracted data into `wb_data`, then go to RESP.
  - `ram_ack`=1 and store: go to IDLE. No write-back.
  - No ack: increment the counter. When the counter equals `MAX_WAIT`, pulse `err`, go to IDLE, and issue no write-back.
  - `ram_ack` and timeout in the same cycle: the ack wins.
- RESP: `wb_valid`=1 and `wb_addr`=latched rd for exactly one cycle, then go to IDLE.
- `ram_ack` outside BUSY is ignored.
- Word accesses ignore `req_addr[1:0]`. `ram_be`=4'hF for word stores and 4'h0 for all reads.
- `stall` = (state != IDLE). `req_ready` = (state == IDLE).

## Timing
- Reset values: `req_ready`=1. `ram_en`, `ram_wr`, `wb_valid`, `stall` and `err` are 0. `ram_addr`, `ram_wdata`, `ram_be`, `wb_addr` and `wb_data` are 0. FSM is IDLE and the counter is 0.
- Request accepted at edge N; `ram_en` is high from cycle N+1.
- Ack sampled at edge M:
  - Load: `wb_valid` is high in cycle M+1, and `req_ready` returns in cycle M+2.
  - Store: `req_ready` returns in cycle M+1.
- Minimum load latency (ack in the first BUSY cycle) is 3 cycles from accept to `req_ready`. Minimum store latency is 2 cycles.
- Timeout: `err` is high in the cycle after the `MAX_WAIT`-th unacknowledged BUSY cycle, together with `req_ready`=1.
- Reset asserted mid-access: `ram_en`, `wb_valid` and `stall` drop immediately (asynchronously). The in-flight access is discarded and no write-back occurs.

## Configuration
- `MEM_ACCESS_BYTE_EN` defined:
  - Byte stores: `ram_be` = 4'b0001 << addr[1:0], and `ram_wdata` = `req_wdata[7:0]` replicated into all four lanes.
  - Byte loads: return lane addr[1:0] of `ram_rdata`, zero-extended to 32 bits.
- Not defined: `req_byte` is ignored and every access is a full word (`ram_be`=4'hF on writes). The lane logic is absent.

## Structure
- Package `mem_access_pkg`: FSM state enum (IDLE, BUSY, RESP), `BE_WORD`=4'hF, `BE_NONE`=4'h0, and the wait-counter width `WAIT_W`=8.
- Sub-module `byte_lane_sel` (combinational): store byte-enable generation and lane replication, plus load lane extraction and zero-extension. It is instantiated only under `MEM_ACCESS_BYTE_EN`.

## Test plan
- Word load: addr 0x0000_0010, rd=5, ack after 2 BUSY cycles with rdata 0xDEAD_BEEF -> `ram_addr`=4, `ram_wr`=0. One `wb_valid` cycle with `wb_addr`=5 and `wb_data`=0xDEAD_BEEF. `stall` high for 3 cycles.
- Word store: addr 0x0000_0020, wdata 0x1234_5678, ack in the first BUSY cycle -> `ram_wr`=1, `ram_addr`=8, `ram_be`=4'hF, no `wb_valid`, `req_ready` high 2 cycles after accept.
- Byte ops (macro defined):
  - STRB to addr 0x23 with wdata 0xAB -> `ram_be`=4'b1000, `ram_wdata`=0xABAB_ABAB.
  - LDRB from 0x22 with rdata 0x11CC_3344 -> `wb_data`=0x0000_00CC.
- Timeout: `MAX_WAIT`=4, never ack -> `ram_en` high for 4 cycles, then an `err` pulse, `req_ready`=1 and no `wb_valid`. A following request is accepted normally.
- Reset mid-access: assert `rst` in the second BUSY cycle -> `ram_en` and `stall` drop in the same cycle. After release the unit is IDLE, and a later stray `ram_ack` produces no `wb_valid`.
- Back-to-back: `req_valid` held high with two loads -> the second is accepted only when `req_ready` is 1, and both write-backs appear in order with the correct `wb_addr`.
